fetch_seq_ctrl: RTL and testbench



---
 rtl/fetch_seq_ctrl_pkg.sv | 20 ++
 rtl/fetch_seq_ctrl_if.sv | 56 +++++
 rtl/fetch_seq_ctrl_load_use_detect.sv | 25 ++
 rtl/fetch_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, the opcodes
// the front end cares about and the RNS register-file flag position.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_e;

  localparam logic [4:0] OP_HALT   = 5'b10110;
  localparam logic [4:0] OP_RLOAD  = 5'b01000;
  localparam logic [4:0] OP_RSTORE = 5'b01001;

  // Bit of a 4-bit operand address selecting the RNS file (1) over the integer file (0).
  localparam int unsigned RNS_FILE_BIT = 3;

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Pipeline-facing signal bundle of the fetch sequencer.
// master: the sequencer itself; slave: the pipeline/memory side.
// Perf-counter outputs exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_seq_ctrl_if #(
  parameter int unsigned PROG_CTR_WID = 10
) ();

  logic                    branch_taken_EX;
  logic [PROG_CTR_WID-1:0] branch_target_EX;
  logic [4:0]              opcode_IFID;
  logic [3:0]              op1_addr_IFID;
  logic [3:0]              op2_addr_IFID;
  logic [2:0]              op3_addr_IFID;
  logic                    store_IFID;
  logic                    ld_pending_EX;
  logic [2:0]              ld_dest_EX;
  logic                    resume;
  logic [PROG_CTR_WID-1:0] instr_mem_addr;
  logic                    fetch_valid;
  logic                    stall_IFID;
  logic                    flush_IFID;
  logic                    halted;
  logic [2:0]              state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]             perf_branch_cnt;
  logic [15:0]             perf_stall_cnt;
  logic [15:0]             perf_halt_cnt;

  modport master (
    input  branch_taken_EX, branch_target_EX, opcode_IFID, op1_addr_IFID, op2_addr_IFID,
           op3_addr_IFID, store_IFID, ld_pending_EX, ld_dest_EX, resume,
    output instr_mem_addr, fetch_valid, stall_IFID, flush_IFID, halted, state_dbg,
           perf_branch_cnt, perf_stall_cnt, perf_halt_cnt
  );

  modport slave (
    output branch_taken_EX, branch_target_EX, opcode_IFID, op1_addr_IFID, op2_addr_IFID,
           op3_addr_IFID, store_IFID, ld_pending_EX, ld_dest_EX, resume,
    input  instr_mem_addr, fetch_valid, stall_IFID, flush_IFID, halted, state_dbg,
           perf_branch_cnt, perf_stall_cnt, perf_halt_cnt
  );
`else
  modport master (
    input  branch_taken_EX, branch_target_EX, opcode_IFID, op1_addr_IFID, op2_addr_IFID,
           op3_addr_IFID, store_IFID, ld_pending_EX, ld_dest_EX, resume,
    output instr_mem_addr, fetch_valid, stall_IFID, flush_IFID, halted, state_dbg
  );

  modport slave (
    output branch_taken_EX, branch_target_EX, opcode_IFID, op1_addr_IFID, op2_addr_IFID,
           op3_addr_IFID, store_IFID, ld_pending_EX, ld_dest_EX, resume,
    input  instr_mem_addr, fetch_valid, stall_IFID, flush_IFID, halted, state_dbg
  );
`endif

endinterface

// File: rtl/fetch_seq_ctrl_load_use_detect.sv
// Combinational load-use hazard compare: an RLOAD in EX whose integer
// destination is read by the instruction in ID. RNS-file operands never match.
module load_use_detect
  import fetch_pkg::*;
(
  input  logic       ld_pending_i,
  input  logic [2:0] ld_dest_i,
  input  logic [3:0] op1_addr_i,
  input  logic [3:0] op2_addr_i,
  input  logic [2:0] op3_addr_i,
  input  logic       store_i,
  output logic       hazard_o
);

  logic op1_hit;
  logic op2_hit;
  logic op3_hit;

  assign op1_hit  = !op1_addr_i[RNS_FILE_BIT] && (op1_addr_i[2:0] == ld_dest_i);
  assign op2_hit  = !op2_addr_i[RNS_FILE_BIT] && (op2_addr_i[2:0] == ld_dest_i);
  // op3 is always an integer-file register, valid only for RSTORE.
  assign op3_hit  = store_i && (op3_addr_i == ld_dest_i);
  assign hazard_o = ld_pending_i && (op1_hit || op2_hit || op3_hit);

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Program-counter sequencer and fetch controller for the 5-stage RISC/RNS pipeline.
// Drives the instruction-memory address, stalls on load-use hazards, redirects and
// flushes on taken EX branches and halts on the HALT opcode.
// Optional macro FETCH_PERF_CNT_EN adds saturating branch/stall/halt counters.
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned PROG_CTR_WID = 10,
  parameter int unsigned RESET_VEC    = 0,
  parameter int unsigned FLUSH_CYCLES = 2   // legal 1..3
) (
  input logic                   clk,
  input logic                   rst,
  fetch_seq_ctrl_if.master      fetch_io
);

  localparam logic [PROG_CTR_WID-1:0] PcReset   = PROG_CTR_WID'(RESET_VEC);
  localparam logic [1:0]              FlushLoad = 2'(FLUSH_CYCLES - 1);

  fetch_state_e            state_q, state_d;
  logic [PROG_CTR_WID-1:0] pc_q, pc_d;
  logic [PROG_CTR_WID-1:0] pc_inc;
  logic [1:0]              cnt_q, cnt_d;
  logic                    fetch_valid_q;
  logic                    halted_q;
  logic                    hazard;
  logic                    stall;
  logic                    flush;
  logic                    is_halt_op;

  load_use_detect u_load_use_detect (
    .ld_pending_i (fetch_io.ld_pending_EX),
    .ld_dest_i    (fetch_io.ld_dest_EX),
    .op1_addr_i   (fetch_io.op1_addr_IFID),
    .op2_addr_i   (fetch_io.op2_addr_IFID),
    .op3_addr_i   (fetch_io.op3_addr_IFID),
    .store_i      (fetch_io.store_IFID),
    .hazard_o     (hazard)
  );

  assign pc_inc     = pc_q + PROG_CTR_WID'(1);  // wraps silently at all-ones
  assign is_halt_op = (fetch_io.opcode_IFID == OP_HALT);

  // Next-state decode; stall/flush are combinational so IF/ID reacts in the event cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (fetch_io.branch_taken_EX) begin
          pc_d    = fetch_io.branch_target_EX;
          cnt_d   = FlushLoad;
          flush   = 1'b1;
          state_d = S_FLUSH;
        end else if (is_halt_op) begin
          state_d = S_HALT;
        end else if (hazard) begin
          stall   = 1'b1;
          state_d = S_STALL;
        end else begin
          pc_d    = pc_inc;
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        // ID holds squashed contents here, so only a new branch is honoured.
        if (fetch_io.branch_taken_EX) begin
          pc_d  = fetch_io.branch_target_EX;
          cnt_d = FlushLoad;
          flush = 1'b1;
        end else begin
          pc_d = pc_inc;
          if (cnt_q == 2'd0) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      S_HALT: begin
        // An older in-flight branch outranks resume.
        if (fetch_io.branch_taken_EX) begin
          pc_d    = fetch_io.branch_target_EX;
          cnt_d   = FlushLoad;
          flush   = 1'b1;
          state_d = S_FLUSH;
        end else if (fetch_io.resume) begin
          pc_d    = pc_inc;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // FSM state, PC and registered fetch qualifiers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_BOOT;
      pc_q          <= PcReset;
      cnt_q         <= 2'd0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= (state_d == S_RUN) || (state_d == S_STALL);
      halted_q      <= (state_d == S_HALT);
    end
  end

  assign fetch_io.instr_mem_addr = pc_q;
  assign fetch_io.fetch_valid    = fetch_valid_q;
  assign fetch_io.stall_IFID     = stall;
  assign fetch_io.flush_IFID     = flush;
  assign fetch_io.halted         = halted_q;
  assign fetch_io.state_dbg      = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] br_cnt_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] halt_cnt_q;

  // Saturating event counters: taken branches, S_STALL cycles, S_HALT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q    <= 16'd0;
      stall_cnt_q <= 16'd0;
      halt_cnt_q  <= 16'd0;
    end else begin
      if (flush && (br_cnt_q != 16'hFFFF)) begin
        br_cnt_q <= br_cnt_q + 16'd1;
      end
      if ((state_q == S_STALL) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if ((state_q == S_HALT) && (halt_cnt_q != 16'hFFFF)) begin
        halt_cnt_q <= halt_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_io.perf_branch_cnt = br_cnt_q;
  assign fetch_io.perf_stall_cnt  = stall_cnt_q;
  assign fetch_io.perf_halt_cnt   = halt_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed, table-driven bench for fetch_seq_ctrl (PROG_CTR_WID=10, RESET_VEC=0,
// FLUSH_CYCLES=2), plus hand sequences for asynchronous reset mid-flush/mid-halt.
module tb_fetch_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_seq_ctrl_if #(.PROG_CTR_WID(10)) bus ();

  fetch_seq_ctrl #(
    .PROG_CTR_WID (10),
    .RESET_VEC    (0),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_io (bus)
  );

  typedef struct {
    logic       br;
    logic [9:0] tgt;
    logic [4:0] opc;
    logic [3:0] op1;
    logic [3:0] op2;
    logic [2:0] op3;
    logic       st;
    logic       ldp;
    logic [2:0] ldd;
    logic       res;
    logic [9:0] e_addr;
    logic       e_fv;
    logic       e_stall;
    logic       e_flush;
    logic       e_halt;
    logic [2:0] e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int br, input int tgt, input int opc, input int op1, input int op2,
                     input int op3, input int st, input int ldp, input int ldd, input int res,
                     input int addr, input int fv, input int stl, input int fl, input int hlt,
                     input int state);
    vec_t v;
    v.br = 1'(br);     v.tgt = 10'(tgt);   v.opc = 5'(opc);    v.op1 = 4'(op1);
    v.op2 = 4'(op2);   v.op3 = 3'(op3);    v.st = 1'(st);      v.ldp = 1'(ldp);
    v.ldd = 3'(ldd);   v.res = 1'(res);    v.e_addr = 10'(addr); v.e_fv = 1'(fv);
    v.e_stall = 1'(stl); v.e_flush = 1'(fl); v.e_halt = 1'(hlt); v.e_state = 3'(state);
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.branch_taken_EX  = v.br;
    bus.branch_target_EX = v.tgt;
    bus.opcode_IFID      = v.opc;
    bus.op1_addr_IFID    = v.op1;
    bus.op2_addr_IFID    = v.op2;
    bus.op3_addr_IFID    = v.op3;
    bus.store_IFID       = v.st;
    bus.ld_pending_EX    = v.ldp;
    bus.ld_dest_EX       = v.ldd;
    bus.resume           = v.res;
  endtask

  task automatic idle();
    vec_t v;
    v = '{br: 1'b0, tgt: 10'h0, opc: 5'h0, op1: 4'h8, op2: 4'h8, op3: 3'd0, st: 1'b0,
          ldp: 1'b0, ldd: 3'd0, res: 1'b0, e_addr: 10'h0, e_fv: 1'b0, e_stall: 1'b0,
          e_flush: 1'b0, e_halt: 1'b0, e_state: 3'd0};
    drive(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " addr"},   32'(bus.instr_mem_addr), 32'h0);
    check({tag, " fv"},     32'(bus.fetch_valid),    32'h0);
    check({tag, " stall"},  32'(bus.stall_IFID),     32'h0);
    check({tag, " flush"},  32'(bus.flush_IFID),     32'h0);
    check({tag, " halted"}, 32'(bus.halted),         32'h0);
    check({tag, " state"},  32'(bus.state_dbg),      32'h0);
`ifdef FETCH_PERF_CNT_EN
    check({tag, " perf_br"},    32'(bus.perf_branch_cnt), 32'h0);
    check({tag, " perf_stall"}, 32'(bus.perf_stall_cnt),  32'h0);
    check({tag, " perf_halt"},  32'(bus.perf_halt_cnt),   32'h0);
`endif
  endtask

  initial begin
    // Columns: br tgt opc op1 op2 op3 st ldp ldd res | addr fv stall flush halted state
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h000, 0, 0, 0, 0, 0); // 0 boot
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h000, 1, 0, 0, 0, 1); // 1 run, fv rises
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h001, 1, 0, 0, 0, 1);
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h002, 1, 0, 0, 0, 1);
    add(0, 'h000,  0, 8, 3,  0, 0, 1, 3, 0,  'h003, 1, 1, 0, 0, 1); // 4 op2 hazard
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h003, 1, 0, 0, 0, 2); // 5 bubble, pc held
    add(0, 'h000,  0, 8, 11, 0, 0, 1, 3, 0,  'h004, 1, 0, 0, 0, 1); // 6 RNS op2: no hazard
    add(0, 'h000,  0, 5, 8,  0, 0, 1, 5, 0,  'h005, 1, 1, 0, 0, 1); // 7 op1 hazard
    add(0, 'h000,  0, 5, 8,  0, 0, 1, 5, 0,  'h005, 1, 1, 0, 0, 2); // 8 persists
    add(0, 'h000,  0, 8, 8,  2, 1, 1, 2, 0,  'h005, 1, 1, 0, 0, 2); // 9 store op3 hazard
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h005, 1, 0, 0, 0, 2); // 10 leave stall
    add(1, 'h055,  0, 8, 3,  0, 0, 1, 3, 0,  'h006, 1, 0, 1, 0, 1); // 11 branch + hazard
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h055, 0, 0, 0, 0, 3);
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h056, 0, 0, 0, 0, 3);
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h057, 1, 0, 0, 0, 1); // 14 valid at 057
    add(0, 'h000, 22, 8, 8,  0, 0, 0, 0, 0,  'h058, 1, 0, 0, 0, 1); // 15 HALT in ID
    add(0, 'h000, 22, 8, 8,  0, 0, 0, 0, 0,  'h058, 0, 0, 0, 1, 4);
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 1,  'h058, 0, 0, 0, 1, 4); // 17 resume
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 1,  'h059, 1, 0, 0, 0, 1); // 18 resume ignored
    add(0, 'h000, 22, 8, 3,  0, 0, 1, 3, 0,  'h05A, 1, 0, 0, 0, 1); // 19 halt beats hazard
    add(1, 'h100,  0, 8, 8,  0, 0, 0, 0, 1,  'h05A, 0, 0, 1, 1, 4); // 20 branch beats resume
    add(1, 'h200,  0, 8, 8,  0, 0, 0, 0, 0,  'h100, 0, 0, 1, 0, 3); // 21 re-branch in flush
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h200, 0, 0, 0, 0, 3);
    add(0, 'h000, 22, 8, 8,  0, 0, 0, 0, 0,  'h201, 0, 0, 0, 0, 3); // 23 HALT ignored
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h202, 1, 0, 0, 0, 1);
    add(1, 'h3FD,  0, 8, 8,  0, 0, 0, 0, 0,  'h203, 1, 0, 1, 0, 1); // 25 branch near top
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h3FD, 0, 0, 0, 0, 3);
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h3FE, 0, 0, 0, 0, 3);
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h3FF, 1, 0, 0, 0, 1); // 28 all-ones
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h000, 1, 0, 0, 0, 1); // 29 wrapped
    add(0, 'h000,  0, 8, 8,  0, 0, 0, 0, 0,  'h001, 1, 0, 0, 0, 1);

    idle();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check($sformatf("step%0d addr", i),   32'(bus.instr_mem_addr), 32'(vecs[i].e_addr));
      check($sformatf("step%0d fv", i),     32'(bus.fetch_valid),    32'(vecs[i].e_fv));
      check($sformatf("step%0d stall", i),  32'(bus.stall_IFID),     32'(vecs[i].e_stall));
      check($sformatf("step%0d flush", i),  32'(bus.flush_IFID),     32'(vecs[i].e_flush));
      check($sformatf("step%0d halted", i), 32'(bus.halted),         32'(vecs[i].e_halt));
      check($sformatf("step%0d state", i),  32'(bus.state_dbg),      32'(vecs[i].e_state));
      @(posedge clk);
      #1;
    end

`ifdef FETCH_PERF_CNT_EN
    check("perf_br after table",    32'(bus.perf_branch_cnt), 32'd4);
    check("perf_stall after table", 32'(bus.perf_stall_cnt),  32'd4);
    check("perf_halt after table",  32'(bus.perf_halt_cnt),   32'd3);
`endif

    // Asynchronous reset in the middle of a flush.
    idle();
    bus.branch_taken_EX  = 1'b1;
    bus.branch_target_EX = 10'h055;
    #1;
    check("flush_seq flush", 32'(bus.flush_IFID), 32'h1);
    @(posedge clk);
    #1;
    idle();
    check("flush_seq state", 32'(bus.state_dbg), 32'd3);
    check("flush_seq addr",  32'(bus.instr_mem_addr), 32'h055);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_in_flush");
    @(posedge clk);
    #1;
    check("rst_in_flush held state", 32'(bus.state_dbg), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_flush run state", 32'(bus.state_dbg),      32'd1);
    check("rst_in_flush run fv",    32'(bus.fetch_valid),    32'h1);
    check("rst_in_flush run addr",  32'(bus.instr_mem_addr), 32'h000);

    // Asynchronous reset while halted.
    bus.opcode_IFID = 5'b10110;
    @(posedge clk);
    #1;
    check("halt_seq halted", 32'(bus.halted), 32'h1);
    check("halt_seq addr",   32'(bus.instr_mem_addr), 32'h000);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_in_halt");
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_halt state",  32'(bus.state_dbg), 32'd1);
    @(posedge clk);
    #1;
    check("rst_in_halt addr",   32'(bus.instr_mem_addr), 32'h001);
    check("rst_in_halt halted", 32'(bus.halted), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
